ifu: RTL
========

# ifu

Instruction fetch unit for the single-issue NPC core. It sits directly downstream of the `pc` stage. It takes the current PC, reads one 32-bit instruction over an AXI-lite-style read channel, and presents the instruction with its PC to decode under a valid/ready handshake. It also pulses `pc_we` to let the `pc` stage advance only after decode has accepted the instruction.

## Interface
- `BITWIDTH`, 32: address/data width; only 32 is supported.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset (sampled on the rising edge of `clk`; 0 = reset).
- `pc`  in  BITWIDTH  current PC from the `pc` stage.
- `pc_we`  out  1  one-cycle pulse: the `pc` stage latches its next PC at this edge.
- `mem_araddr`  out  BITWIDTH  fetch address.
- `mem_arvalid`  out  1  read request valid.
- `mem_arready`  in  1  memory accepts request.
- `mem_rdata`  in  32  instruction word.
- `mem_rresp`  in  2  response code; 2'b00 = OKAY, any other value = error.
- `mem_rvalid`  in  1  response valid.
- `mem_rready`  out  1  IFU accepts response.
- `out_inst`  out  32  fetched instruction.
- `out_pc`  out  BITWIDTH  PC of `out_inst`.
- `out_valid`  out  1  instruction available to decode.
- `out_ready`  in  1  decode accepts instruction.
- `out_access_fault`  out  1  `mem_rresp` was not OKAY for this fetch.
- `out_misalign`  out  1  PC was not word-aligned (see Configuration).

## Operation
- State machine `REQ`, `WAIT`, `HOLD`. Reset state is `REQ`.
- `REQ`
  - `mem_arvalid=1` and `mem_araddr=pc`; `pc` is captured into `out_pc`.
  - On `mem_arready=1`, go to `WAIT`.
  - `mem_araddr` must stay stable while `arvalid` is high and unaccepted.
- `WAIT`
  - `mem_rready=1`.
  - On `mem_rvalid=1`, latch `mem_rdata` into `out_inst` and set `out_access_fault = (mem_rresp != 2'b00)`, then go to `HOLD`.
  - A response is never accepted in `REQ`; memory guarantees `rvalid` no earlier than the cycle after the AR handshake.
- `HOLD`
  - `out_valid=1`; `out_inst`, `out_pc` and the fault flags are held stable.
  - On `out_ready=1`, pulse `pc_we=1` for exactly that cycle and go to `REQ`.
  - The `pc` stage updates at the same edge, so the next `REQ` issues the new PC.
- Outputs are registered.
  - `mem_arvalid`, `mem_rready`, `out_valid` and `pc_we` are decoded from the state; `pc_we = (state==HOLD) & out_ready`.
- At most one fetch is outstanding; there is no prefetch.
- An access fault does not stall the unit. The faulting word is handed to decode with the flag set, and exception handling is downstream (mtvec selection in `pc`).

## Timing
- Reset values: state `REQ`; `out_inst=32'h0000_0013` (NOP); `out_pc=0`; `out_access_fault=0`; `out_misalign=0`; `pc_we=0`; `out_valid=0`; `mem_rready=0`.
- `mem_arvalid` is 1 from the first cycle after reset is released.
- Minimum loop is 3 cycles per instruction: `REQ` (arready=1), `WAIT` (rvalid=1), `HOLD` (out_ready=1).
- Each extra cycle of `arready=0`, `rvalid=0` or `out_ready=0` adds exactly one cycle.
- `out_ready` asserted before `out_valid` has no effect; `pc_we` never pulses outside `HOLD`.
- Reset asserted in any state returns to `REQ` on that edge and discards any captured instruction. Memory is reset by the same `rst`, so no stale response arrives afterwards.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined:
  - In `REQ`, if `pc[1:0] != 0`, no AR request is issued (`mem_arvalid=0`).
  - Next cycle goes directly to `HOLD` with `out_misalign=1`, `out_inst=NOP`, `out_access_fault=0`.
  - `HOLD`/`pc_we` behaviour is unchanged.
- Undefined: no alignment check. `mem_araddr=pc` unconditionally and `out_misalign` is tied to 0.

## Structure
- Shared package `ifu_pkg`:
  - state encoding (`IFU_REQ=2'd0`, `IFU_WAIT=2'd1`, `IFU_HOLD=2'd2`);
  - `RESP_OKAY=2'b00`;
  - `INST_NOP=32'h0000_0013`.
- One sub-module `ifu_out_reg`: holding register for `out_inst`, `out_pc` and the fault flags, with load enable and reset. The FSM stays in `ifu`.

## Test plan
- **Back-to-back fetch:** memory with zero wait states, `out_ready=1`, `pc` stepping 0x80000000 then 0x80000004. Expect requests to those addresses, `out_valid` every third cycle, and `pc_we` pulsed once per instruction.
- **Memory stalls:** `arready` delayed 2 cycles, `rvalid` delayed 3 cycles, `rdata=0x00500093`. Expect `araddr` stable while `arready=0`, then `out_inst=0x00500093` and `out_pc=0x80000000` after 8 cycles total.
- **Decode backpressure:** `out_ready=0` for 5 cycles in `HOLD`. Expect `out_valid`, `out_inst` and `out_pc` held, no new request, and `pc_we=0` until the accepting cycle.
- **Access fault:** `rresp=2'b10`. Expect `out_access_fault=1` with `out_valid`, flag cleared on the next fetch with OKAY.
- **Misalign** (`IFU_MISALIGN_CHECK_EN` defined): `pc=0x80000002`. Expect no `arvalid`, then `out_misalign=1` and `out_inst=0x00000013`.
- **Reset mid-operation:** `rst=0` while in `WAIT`. Expect all outputs at reset values next cycle, then after release a new request at the current `pc`.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The FSM state encoding, the response code and the NOP instruction word live here.
package ifu_pkg;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_HOLD = 2'd2
    } ifu_state_t;

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;

    function automatic logic resp_is_fault(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/ifu_out_reg.sv
// Holding register for the instruction, its PC and the fault flags handed to decode.
// The PC half and the instruction half load independently, so the PC is latched at the AR handshake.
module ifu_out_reg
    import ifu_pkg::*;
#(
    parameter int BITWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_load,
    input  logic [BITWIDTH-1:0] pc_d,
    input  logic                misalign_d,
    input  logic                inst_load,
    input  logic [31:0]         inst_d,
    input  logic                fault_d,
    output logic [31:0]         out_inst,
    output logic [BITWIDTH-1:0] out_pc,
    output logic                out_access_fault,
    output logic                out_misalign
);

    logic [31:0]         inst_reg;
    logic [BITWIDTH-1:0] pc_reg;
    logic                fault_reg;
    logic                misalign_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_reg       <= '0;
            misalign_reg <= 1'b0;
        end else if (pc_load) begin
            pc_reg       <= pc_d;
            misalign_reg <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_reg  <= INST_NOP;
            fault_reg <= 1'b0;
        end else if (inst_load) begin
            inst_reg  <= inst_d;
            fault_reg <= fault_d;
        end
    end

    assign out_inst         = inst_reg;
    assign out_pc           = pc_reg;
    assign out_access_fault = fault_reg;
    assign out_misalign     = misalign_reg;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding AXI-lite read per instruction, handed to decode via valid/ready.
// Optional alignment check enabled by defining IFU_MISALIGN_CHECK_EN.
module ifu
    import ifu_pkg::*;
#(
    parameter int BITWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITWIDTH-1:0] pc,
    output logic                pc_we,
    output logic [BITWIDTH-1:0] mem_araddr,
    output logic                mem_arvalid,
    input  logic                mem_arready,
    input  logic [31:0]         mem_rdata,
    input  logic [1:0]          mem_rresp,
    input  logic                mem_rvalid,
    output logic                mem_rready,
    output logic [31:0]         out_inst,
    output logic [BITWIDTH-1:0] out_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_access_fault,
    output logic                out_misalign
);

    ifu_state_t  state_reg;
    ifu_state_t  state_next;
    logic        misaligned;
    logic        pc_load;
    logic        inst_load;
    logic [31:0] inst_d;
    logic        fault_d;

`ifdef IFU_MISALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IFU_REQ;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_load    = 1'b0;
        inst_load  = 1'b0;
        inst_d     = mem_rdata;
        fault_d    = resp_is_fault(mem_rresp);
        case (state_reg)
            IFU_REQ: begin
                // A misaligned PC never reaches memory; decode gets a NOP tagged with the flag.
                if (misaligned) begin
                    state_next = IFU_HOLD;
                    pc_load    = 1'b1;
                    inst_load  = 1'b1;
                    inst_d     = INST_NOP;
                    fault_d    = 1'b0;
                end else if (mem_arready) begin
                    state_next = IFU_WAIT;
                    pc_load    = 1'b1;
                end
            end
            IFU_WAIT: begin
                if (mem_rvalid) begin
                    state_next = IFU_HOLD;
                    inst_load  = 1'b1;
                end
            end
            IFU_HOLD: begin
                if (out_ready) begin
                    state_next = IFU_REQ;
                end
            end
            default: begin
                state_next = IFU_REQ;
            end
        endcase
    end

    // The request address follows pc directly; pc only moves on pc_we, so it is stable while unaccepted.
    assign mem_araddr  = pc;
    assign mem_arvalid = rst & (state_reg == IFU_REQ) & ~misaligned;
    assign mem_rready  = (state_reg == IFU_WAIT);
    assign out_valid   = (state_reg == IFU_HOLD);
    assign pc_we       = (state_reg == IFU_HOLD) & out_ready;

    ifu_out_reg #(
        .BITWIDTH (BITWIDTH)
    ) u_out_reg (
        .clk              (clk),
        .rst              (rst),
        .pc_load          (pc_load),
        .pc_d             (pc),
        .misalign_d       (misaligned),
        .inst_load        (inst_load),
        .inst_d           (inst_d),
        .fault_d          (fault_d),
        .out_inst         (out_inst),
        .out_pc           (out_pc),
        .out_access_fault (out_access_fault),
        .out_misalign     (out_misalign)
    );

endmodule
